// File: rtl/pipe_mem_sched.sv
// Purpose: shares one single-ported memory between instruction fetch and M-stage data access.
// Latency: 3 cycles per step with zero-wait memory (4 with a data access), +1 per memory wait cycle.
// Backpressure: holds Enable low until MemAck arrives, or until the timeout completes the access.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   PC                fetch address from the datapath
//   DReq/DWe          M stage wants a data access / access is a store
//   ALUOutM           data address
//   WriteDataM        store data
//   InstrF            latched fetched instruction
//   ReadDataM         latched load data
//   Enable            one-cycle pipeline advance strobe
//   MemReq/MemWe      memory request / request is a write
//   MemAddr/MemWData  memory request address / write data
//   MemRData/MemAck   memory read data / one-cycle completion pulse
//   MemErr            sticky timeout flag
//   StallCount        saturating count of cycles with Enable low
module pipe_mem_sched #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] InstrF,
  output logic [31:0] ReadDataM,
  output logic        Enable,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        MemErr,
  output logic [15:0] StallCount
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] STEP  = 2'd3;

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [1:0]    state, state_nxt;
  logic [TW-1:0] tcnt;
  logic          in_acc;
  logic          tmo;
  logic          done;
  logic [31:0]   rword;

  assign in_acc = (state == DATA) || (state == FETCH);
  assign tmo    = (tcnt == TLAST);
  // An ack on the final timeout cycle still counts as a good completion.
  assign done   = in_acc && (MemAck || tmo);
  assign rword  = MemAck ? MemRData : 32'h0;

  // Memory-side outputs come straight from the state register so they never
  // see MemAck and cannot glitch.
  assign MemReq   = in_acc;
  assign MemWe    = (state == DATA) && DWe;
  assign MemAddr  = (state == DATA)  ? ALUOutM :
                    (state == FETCH) ? PC      : 32'h0;
  assign MemWData = (state == DATA)  ? WriteDataM : 32'h0;
  assign Enable   = (state == STEP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = DReq ? DATA : FETCH;
      DATA:    if (done) state_nxt = FETCH;
      FETCH:   if (done) state_nxt = STEP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      InstrF     <= 32'h0;
      ReadDataM  <= 32'h0;
      MemErr     <= 1'b0;
      StallCount <= 16'h0;
    end else begin
      state <= state_nxt;

      // Restart the wait counter for every new access, including the
      // back-to-back DATA -> FETCH handover.
      if (!in_acc || done)
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);

      if (state == FETCH && done)
        InstrF <= rword;
      if (state == DATA && done && !DWe)
        ReadDataM <= rword;

      if (in_acc && tmo && !MemAck)
        MemErr <= 1'b1;

      if (!Enable && StallCount != 16'hFFFF)
        StallCount <= StallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_mem_sched.sv
module tb_pipe_mem_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC, ALUOutM, WriteDataM;
  logic        DReq, DWe;
  logic [31:0] InstrF, ReadDataM, MemAddr, MemWData, MemRData;
  logic        Enable, MemReq, MemWe, MemAck, MemErr;
  logic [15:0] StallCount;

  // Second instance: never acked, huge timeout, used for StallCount saturation.
  logic        rst2;
  logic [31:0] InstrF2, ReadDataM2, MemAddr2, MemWData2;
  logic        Enable2, MemReq2, MemWe2, MemErr2;
  logic [15:0] StallCount2;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = 32'h1234_5678;

  always #5 clk = ~clk;

  pipe_mem_sched #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .PC(PC), .DReq(DReq), .DWe(DWe),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .InstrF(InstrF),
    .ReadDataM(ReadDataM), .Enable(Enable), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData),
    .MemAck(MemAck), .MemErr(MemErr), .StallCount(StallCount)
  );

  pipe_mem_sched #(.TIMEOUT(100000)) dut2 (
    .clk(clk), .reset(rst2), .PC(PC), .DReq(1'b0), .DWe(1'b0),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .InstrF(InstrF2),
    .ReadDataM(ReadDataM2), .Enable(Enable2), .MemReq(MemReq2), .MemWe(MemWe2),
    .MemAddr(MemAddr2), .MemWData(MemWData2), .MemRData(rdata2),
    .MemAck(ack2), .MemErr(MemErr2), .StallCount(StallCount2)
  );

  // Memory model: acks after 'lat' wait cycles of each access, never when hung.
  logic        mack_m = 1'b0;
  logic        stray  = 1'b0;
  bit          hang   = 1'b0;
  int          cnt    = 0;
  int          lat    = 0;
  logic [31:0] instr_val, data_val;

  always @(negedge clk) begin
    if (!MemReq) begin
      cnt    = 0;
      mack_m = 1'b0;
    end else begin
      if (mack_m) cnt = 0;
      mack_m = !hang && (cnt == lat);
      cnt    = cnt + 1;
    end
  end

  assign MemAck   = mack_m | stray;
  assign MemRData = MemWe ? 32'hBAD0_BAD0 : ((MemAddr == PC) ? instr_val : data_val);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; rst2 = 1'b0;
    PC = 32'h0; DReq = 1'b0; DWe = 1'b0; ALUOutM = 32'h0; WriteDataM = 32'h0;
    instr_val = 32'hE3A0_1005; data_val = 32'hDEAD_BEEF;
    repeat (2) tick();

    // Reset state
    check("rst_instr",  InstrF, 32'h0);
    check("rst_rdata",  ReadDataM, 32'h0);
    check("rst_enable", Enable, 1'b0);
    check("rst_memreq", MemReq, 1'b0);
    check("rst_memwe",  MemWe, 1'b0);
    check("rst_addr",   MemAddr, 32'h0);
    check("rst_wdata",  MemWData, 32'h0);
    check("rst_err",    MemErr, 1'b0);
    check("rst_stall",  StallCount, 16'h0);

    // Zero-wait fetch: cycle 0 IDLE, 1 FETCH, 2 STEP
    reset = 1'b1; rst2 = 1'b1;
    check("zw_c0_req", MemReq, 1'b0);
    tick();
    check("zw_c1_req",  MemReq, 1'b1);
    check("zw_c1_addr", MemAddr, 32'h0);
    check("zw_c1_we",   MemWe, 1'b0);
    tick();
    check("zw_c2_en",    Enable, 1'b1);
    check("zw_c2_instr", InstrF, 32'hE3A0_1005);
    check("zw_c2_stall", StallCount, 16'd2);
    check("zw_c2_req",   MemReq, 1'b0);
    for (int k = 0; k < 2; k++) begin
      repeat (2) begin
        tick();
        check("zw_en_low", Enable, 1'b0);
      end
      tick();
      check("zw_en_pulse", Enable, 1'b1);
    end
    check("zw_stall6", StallCount, 16'd6);

    // Load with two wait cycles (address held 3 cycles), fetch also waits
    DReq = 1'b1; DWe = 1'b0; ALUOutM = 32'h100; PC = 32'h4;
    instr_val = 32'hE081_1002; lat = 2;
    tick();
    check("ld_idle_req", MemReq, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ld_addr", MemAddr, 32'h100);
      check("ld_en",   Enable, 1'b0);
    end
    tick();
    check("ld_fetch_addr", MemAddr, 32'h4);
    check("ld_rdata",      ReadDataM, 32'hDEAD_BEEF);
    repeat (2) begin
      tick();
      check("ld_fetch_en", Enable, 1'b0);
    end
    tick();
    check("ld_step_en",    Enable, 1'b1);
    check("ld_step_instr", InstrF, 32'hE081_1002);

    // Store: write strobe and data, ReadDataM untouched
    lat = 0; DWe = 1'b1; ALUOutM = 32'h200; WriteDataM = 32'h55; PC = 32'h8;
    instr_val = 32'hE580_1000;
    tick();
    tick();
    check("st_we",    MemWe, 1'b1);
    check("st_wdata", MemWData, 32'h55);
    check("st_addr",  MemAddr, 32'h200);
    tick();
    check("st_f_we",    MemWe, 1'b0);
    check("st_f_wdata", MemWData, 32'h0);
    check("st_f_addr",  MemAddr, 32'h8);
    check("st_f_rdata", ReadDataM, 32'hDEAD_BEEF);
    tick();
    check("st_en",    Enable, 1'b1);
    check("st_instr", InstrF, 32'hE580_1000);
    check("st_rdata", ReadDataM, 32'hDEAD_BEEF);

    // Fetch timeout with TIMEOUT=4
    DReq = 1'b0; DWe = 1'b0; PC = 32'hC; hang = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_req", MemReq, 1'b1);
      check("to_err", MemErr, 1'b0);
    end
    tick();
    check("to_en",    Enable, 1'b1);
    check("to_instr", InstrF, 32'h0);
    check("to_err1",  MemErr, 1'b1);

    // Good access after timeout: error stays sticky
    hang = 1'b0; PC = 32'h10; instr_val = 32'hE1A0_0000;
    repeat (3) tick();
    check("ok_en",    Enable, 1'b1);
    check("ok_instr", InstrF, 32'hE1A0_0000);
    check("ok_err",   MemErr, 1'b1);

    // Reset during a DATA wait: MemReq drops without a clock edge
    DReq = 1'b1; ALUOutM = 32'h300; hang = 1'b1;
    repeat (3) tick();
    check("rm_req_pre", MemReq, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rm_req_async", MemReq, 1'b0);
    check("rm_err",       MemErr, 1'b0);
    check("rm_stall",     StallCount, 16'h0);
    hang = 1'b0; lat = 0; PC = 32'h14; instr_val = 32'hE280_0001;
    tick();
    reset = 1'b1; stray = 1'b1;
    check("rm_c0_req", MemReq, 1'b0);
    tick();
    stray = 1'b0;
    check("rm_data_req",  MemReq, 1'b1);
    check("rm_data_addr", MemAddr, 32'h300);
    tick();
    lat = 3;
    check("rm_fetch_addr", MemAddr, 32'h14);
    check("rm_rdata",      ReadDataM, 32'hDEAD_BEEF);
    repeat (3) tick();
    check("ab_req_c4", MemReq, 1'b1);
    check("ab_en_c4",  Enable, 1'b0);
    tick();
    check("ab_en",    Enable, 1'b1);
    check("ab_instr", InstrF, 32'hE280_0001);
    check("ab_err",   MemErr, 1'b0);

    // Saturation on the never-acked instance
    repeat (66000) tick();
    check("sat_stall", StallCount2, 16'hFFFF);
    check("sat_req",   MemReq2, 1'b1);
    check("sat_err",   MemErr2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_mem_sched.md
# pipe_mem_sched

Sequencer that shares one single-ported unified memory between the instruction-fetch port and the data-memory port of the five-stage pipelined ARM datapath. It issues the accesses each pipeline step needs, waits on a variable-latency memory handshake, and drives the datapath's `Enable` for exactly one cycle once the fetched instruction and any data-read word are ready. It sits between the datapath (PC, InstrF, ALUOutM, WriteDataM, ReadDataM, Enable) and the external memory.

## Interface
- `TIMEOUT`, 16: maximum cycles one access waits for `MemAck`. Minimum 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = in reset.
- `PC`  in  32  fetch address from the datapath.
- `DReq`  in  1  M stage needs a data access (load or store).
- `DWe`  in  1  M-stage access is a store; valid only with `DReq`.
- `ALUOutM`  in  32  data address.
- `WriteDataM`  in  32  store data.
- `InstrF`  out  32  latched fetched instruction.
- `ReadDataM`  out  32  latched load data.
- `Enable`  out  1  pipeline advance strobe.
- `MemReq`  out  1  memory request.
- `MemWe`  out  1  request is a write.
- `MemAddr`  out  32  request address.
- `MemWData`  out  32  request write data.
- `MemRData`  in  32  memory read data; valid when `MemAck`=1.
- `MemAck`  in  1  one-cycle completion pulse; ignored while `MemReq`=0.
- `MemErr`  out  1  sticky timeout flag.
- `StallCount`  out  16  saturating count of cycles with `Enable`=0.

## Operation
- FSM states: IDLE, DATA, FETCH, STEP. Reset state IDLE.
- IDLE: `DReq`=1 -> DATA; else -> FETCH.
- DATA: `MemReq`=1, `MemAddr`=`ALUOutM`, `MemWe`=`DWe`, `MemWData`=`WriteDataM`. On completion -> FETCH. If it was a read, load `ReadDataM`. A store leaves `ReadDataM` unchanged.
- FETCH: `MemReq`=1, `MemAddr`=`PC`, `MemWe`=0, `MemWData`=0. On completion, load `InstrF` -> STEP.
- STEP: `Enable`=1, `MemReq`=0 -> IDLE.
- IDLE exists so that `DReq`, `PC` and the M-stage inputs are sampled only after the pipeline registers have updated.
- Data access always precedes fetch, because the older instruction has priority.
- `MemReq`, `MemWe`, `MemAddr`, `MemWData` and `Enable` are decoded from the state register only, so they are glitch-free and never depend on `MemAck`. Outside DATA and FETCH, `MemReq`, `MemWe`, `MemAddr` and `MemWData` are 0.
- Completion means `MemAck`=1 sampled at a rising edge while in DATA or FETCH.
- Timeout counter:
  - Cleared on entry to DATA or FETCH; increments each cycle without an ack.
  - When it reaches `TIMEOUT-1` with no ack, the access completes with data 32'h0 and `MemErr` sets to 1. `MemErr` stays 1 until reset.
  - If ack and timeout occur in the same cycle, the ack wins: `MemRData` is used and `MemErr` is not set.
- `StallCount`: increments every cycle `Enable`=0 while out of reset; saturates at 16'hFFFF; never wraps.
- Reset mid-access:
  - Asserting `reset` low forces IDLE immediately, so `MemReq` drops asynchronously.
  - The memory discards any outstanding access. A late `MemAck` is ignored.
- Input changes during DATA or FETCH are illegal. The datapath cannot change them while `Enable`=0. Outputs follow the live inputs.

## Timing
- Reset values: state IDLE; `InstrF`=0, `ReadDataM`=0, `Enable`=0, `MemReq`=0, `MemErr`=0, `StallCount`=0. Outputs decoded from state (`MemWe`, `MemAddr`, `MemWData`) are 0.
- With a zero-wait memory (ack in the first cycle of the request), one pipeline step takes:
  - 3 cycles without a data access (IDLE, FETCH, STEP);
  - 4 cycles with a data access (IDLE, DATA, FETCH, STEP).
- Each memory wait cycle adds one cycle.
- `Enable` is high for exactly one cycle per step, never back-to-back.
- `InstrF` and `ReadDataM` change only on the completing edge and are stable during STEP.
- `MemReq` deasserts in the cycle after the completing edge, or the next access starts in that cycle.
- First fetch after reset release: IDLE at cycle 0, `MemReq`=1 at `PC` in cycle 1.

## Test plan
- Zero-wait fetch: reset released, `PC`=0, `DReq`=0, ack immediately, `MemRData`=32'hE3A01005 -> `InstrF`=32'hE3A01005; `Enable` pulses in cycle 2 and every 3 cycles thereafter; `StallCount`=2 at the first pulse.
- Load with waits: `DReq`=1, `DWe`=0, `ALUOutM`=32'h100, ack after 3 cycles with 32'hDEADBEEF -> `MemAddr`=32'h100 held 3 cycles, `ReadDataM`=32'hDEADBEEF; then fetch at `PC`; `Enable` pulses only after the fetch ack.
- Store: `DReq`=1, `DWe`=1, `ALUOutM`=32'h200, `WriteDataM`=32'h55 -> `MemWe`=1, `MemWData`=32'h55; `ReadDataM` keeps its prior value; fetch follows with `MemWe`=0.
- Timeout: `TIMEOUT`=4, `MemAck` held 0 in FETCH -> completes after 4 cycles, `InstrF`=0, `MemErr`=1 and still 1 after later good accesses. Ack on the 4th cycle instead -> `MemErr` stays 0.
- Reset mid-access: assert `reset`=0 during a DATA wait -> `MemReq`=0 without waiting for a clock edge; after release the sequence restarts from IDLE; a stray `MemAck` is ignored.
- Saturation: hold `MemAck`=0 with a large `TIMEOUT` for over 65535 cycles -> `StallCount` stops at 16'hFFFF.
